// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LD_LEN,
        LD_DATA,
        LD_RUN,
        LD_ERROR
    } loader_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_dp.sv
// DEPTH x 32 memory: one synchronous write port, one asynchronous read port.
module imem_dp #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The CPU fetch path is combinational, so the read is deliberately unregistered.
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// Packs a length-prefixed little-endian byte stream into instruction memory and
// holds the CPU in reset until the whole program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_loader_if.slave             stream,
    input  logic                     reload,
    input  logic [31:0]              pc,
    output logic [31:0]              instruction,
    output logic                     cpu_rst_n,
    output logic [$clog2(DEPTH):0]   loaded_words,
    output logic                     error
);
    localparam int AW = $clog2(DEPTH);

    loader_state_t state_reg, state_next;
    logic [31:0]   count_reg, count_next;
    logic [1:0]    idx_reg, idx_next;
    logic [23:0]   shreg_reg, shreg_next;
    logic [AW-1:0] waddr_reg, waddr_next;
    logic [AW:0]   loaded_reg, loaded_next;

    logic          accept;
    logic          we;
    logic [31:0]   header;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [AW-1:0] raddr;
    logic          fetch_ok;
    logic          unused_pc_bits;

    assign stream.in_ready = (state_reg == LD_LEN) || (state_reg == LD_DATA);
    assign accept          = stream.in_valid && stream.in_ready;
    assign header          = {stream.in_data, count_reg[31:8]};
    assign wdata           = {stream.in_data, shreg_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= LD_LEN;
            count_reg  <= '0;
            idx_reg    <= '0;
            shreg_reg  <= '0;
            waddr_reg  <= '0;
            loaded_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            idx_reg    <= idx_next;
            shreg_reg  <= shreg_next;
            waddr_reg  <= waddr_next;
            loaded_reg <= loaded_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        idx_next    = idx_reg;
        shreg_next  = shreg_reg;
        waddr_next  = waddr_reg;
        loaded_next = loaded_reg;
        we          = 1'b0;

        case (state_reg)
            LD_LEN: begin
                if (accept) begin
                    count_next = header;
                    idx_next   = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        if (header == 32'd0) begin
                            state_next = LD_RUN;
                        end else if (header > 32'(DEPTH)) begin
                            state_next = LD_ERROR;
                        end else begin
                            state_next = LD_DATA;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (accept) begin
                    shreg_next = {stream.in_data, shreg_reg[23:8]};
                    idx_next   = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        we          = 1'b1;
                        loaded_next = loaded_reg + 1'b1;
                        // Hold waddr on the final word so it never steps past DEPTH-1.
                        if (32'(loaded_reg) + 32'd1 == count_reg) begin
                            state_next = LD_RUN;
                        end else begin
                            waddr_next = waddr_reg + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (reload) begin
                    state_next  = LD_LEN;
                    count_next  = '0;
                    idx_next    = '0;
                    shreg_next  = '0;
                    waddr_next  = '0;
                    loaded_next = '0;
                end
            end
        endcase
    end

    imem_dp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr_reg),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Anything not yet written in the current load reads as NOP, hiding stale words.
    assign raddr          = pc[AW+1:2];
    assign fetch_ok       = (pc[31:AW+2] == '0) && ({1'b0, raddr} < loaded_reg);
    assign instruction    = fetch_ok ? rdata : INSTR_NOP;
    assign unused_pc_bits = ^pc[1:0];

    assign cpu_rst_n    = (state_reg == LD_RUN);
    assign error        = (state_reg == LD_ERROR);
    assign loaded_words = loaded_reg;
endmodule
